rf_mp_sb: RTL and testbench
===========================

# rf_mp_sb

Parametrised multi-port register file with a per-register scoreboard, for the pipelined core's decode stage. It provides NUM_RD combinational read ports with write-first bypass from two write-back ports, so a same-cycle write-back is visible without an extra forwarding mux. A busy bit per register tracks outstanding writes; decode uses it to stall on RAW hazards. Register 0 reads as zero, is never busy, and ignores writes.

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; depth is 2**ADDR_W.
- NUM_RD, 2: number of read ports, ≥1.

Ports:
- clk  in  1: single clock; state updates on the rising edge.
- rst  in  1: asynchronous, active-high reset.
- rR  in  NUM_RD*ADDR_W: read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rD  out  NUM_RD*DATA_W: read data; port k uses bits [k*DATA_W +: DATA_W].
- rbusy  out  NUM_RD: port k's register has a pending write not satisfied this cycle.
- we0 / wR0 / wD0  in  1 / ADDR_W / DATA_W: write-back port 0.
- we1 / wR1 / wD1  in  1 / ADDR_W / DATA_W: write-back port 1; wins over port 0.
- iss_v / iss_rd  in  1 / ADDR_W: issue of an instruction that will write iss_rd; sets the busy bit.
- flush  in  1: clears all busy bits; register contents are kept.

## Operation
- Storage is 2**ADDR_W × DATA_W registers plus a 2**ADDR_W busy vector.
- Write, at posedge:
  - If we1 and wR1≠0, then rf[wR1] ← wD1.
  - If we0 and wR0≠0 and no port-1 write to the same address, then rf[wR0] ← wD0.
  - Writes to address 0 are dropped.
- Read, combinational, per port k with a = rR[k]:
  - a=0 → 0.
  - else we1 and wR1=a → wD1.
  - else we0 and wR0=a → wD0.
  - else rf[a].
- Busy clear: an effective write to address a clears busy[a]. A write qualifies as effective under the same conditions as a register write, on either port.
- Busy set: iss_v with iss_rd≠0 sets busy[iss_rd]. Set wins over clear in the same cycle, because the issuing instruction is younger.
- Flush has the highest priority and clears all busy bits. An iss_v in the same cycle is ignored.
- rbusy[k] = busy[a] and not (effective write to a this cycle); forced to 0 for a=0.
- Busy bits are not counted. A second issue to an already busy register leaves it busy, and the first write-back clears it; the pipeline guarantees in-order write-back per register.

## Timing
- Reset (rst=1, asynchronous): all registers 0, all busy bits 0. While rst is high, rD=0 and rbusy=0 for all ports.
- Read latency: 0 cycles, combinational from rR, w*, and stored state.
- Write latency: a value written at edge N is read from storage from cycle N onward; in cycle N−1 it is supplied by bypass.
- Busy latency: a set at edge N makes rbusy visible in the cycle after edge N. A clear is visible immediately in the same cycle through the write qualification.
- Reset asserted mid-operation overrides any pending write, issue, or flush in that cycle. On rst deassertion, the state is fully zero.
- Changing any parameter changes no behaviour except sizes.

## Test plan
- Reset: write 0xDEADBEEF to x5, then pulse rst asynchronously between edges → rD for x5 is 0 immediately and stays 0 after the next edge; all rbusy=0.
- x0 protection: we0=1, wR0=0, wD0=0x1234 → a read of x0 returns 0 in the same cycle and after the edge; an issue to x0 leaves rbusy=0.
- Bypass and priority: in the same cycle we0 writes x7←0x11 and we1 writes x7←0x22 → rD(x7)=0x22 in that cycle, and stored x7=0x22 after the edge. Also check NUM_RD=3 with all ports reading x7.
- Scoreboard: issue x3 at cycle 1 → rbusy=1 in cycles 2–4. Write-back of x3 in cycle 5 → rbusy=0 and rD is the new value in cycle 5.
- Set/clear collision: busy x9, then in one cycle issue x9 and write back x9 → x9 stays busy next cycle and data is updated. Flush plus issue x9 in the same cycle → x9 is not busy afterwards.
- Parameter sweep: DATA_W=64, ADDR_W=3 → writing 0xFFFF_FFFF_0000_0001 to x7 reads back exactly; an 8-entry random write/read test matches the model.

Source files
------------

// File: rtl/rf_mp_sb_if.sv
// Decode-stage register-file bus: read ports, two write-back ports, issue and flush.
interface rf_mp_sb_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NUM_RD = 2
);
   logic [NUM_RD*ADDR_W-1:0] rR;
   logic [NUM_RD*DATA_W-1:0] rD;
   logic [NUM_RD-1:0]        rbusy;
   logic                     we0;
   logic [ADDR_W-1:0]        wR0;
   logic [DATA_W-1:0]        wD0;
   logic                     we1;
   logic [ADDR_W-1:0]        wR1;
   logic [DATA_W-1:0]        wD1;
   logic                     iss_v;
   logic [ADDR_W-1:0]        iss_rd;
   logic                     flush;

   modport master (
      output rR, we0, wR0, wD0, we1, wR1, wD1, iss_v, iss_rd, flush,
      input  rD, rbusy
   );

   modport slave (
      input  rR, we0, wR0, wD0, we1, wR1, wD1, iss_v, iss_rd, flush,
      output rD, rbusy
   );
endinterface

// File: rtl/rf_mp_sb.sv
// Multi-port register file with write-first bypass and a per-register busy scoreboard.
// x0 is hardwired to zero and never busy; write-back port 1 wins over port 0.
module rf_mp_sb #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NUM_RD = 2
) (
   input logic        clk,
   input logic        rst,
   rf_mp_sb_if.slave  bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] rf_q [DEPTH];
   logic [DATA_W-1:0] rf_d [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;

   logic eff0_c;
   logic eff1_c;

   logic [NUM_RD-1:0][DATA_W-1:0] rd_c;
   logic [NUM_RD-1:0]             rbusy_c;

   // Effective writes: x0 dropped, port 0 suppressed when port 1 hits the same register
   assign eff1_c = bus.we1 && (bus.wR1 != '0);
   assign eff0_c = bus.we0 && (bus.wR0 != '0) && !(eff1_c && (bus.wR1 == bus.wR0));

   always_comb begin
      rf_d   = rf_q;
      busy_d = busy_q;
      if (eff0_c) begin
         rf_d[bus.wR0]   = bus.wD0;
         busy_d[bus.wR0] = 1'b0;
      end
      if (eff1_c) begin
         rf_d[bus.wR1]   = bus.wD1;
         busy_d[bus.wR1] = 1'b0;
      end
      // Issue is younger than any write-back this cycle, so set overrides clear
      if (bus.iss_v && (bus.iss_rd != '0)) begin
         busy_d[bus.iss_rd] = 1'b1;
      end
      if (bus.flush) begin
         busy_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_q   <= '{default: '0};
         busy_q <= '0;
      end else begin
         rf_q   <= rf_d;
         busy_q <= busy_d;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] a_c;
      logic              hit0_c;
      logic              hit1_c;

      assign a_c    = bus.rR[k*ADDR_W +: ADDR_W];
      assign hit1_c = eff1_c && (bus.wR1 == a_c);
      assign hit0_c = eff0_c && (bus.wR0 == a_c);

      assign rd_c[k] = (rst || (a_c == '0)) ? '0 :
                       hit1_c               ? bus.wD1 :
                       hit0_c               ? bus.wD0 :
                                              rf_q[a_c];

      // A write-back landing this cycle satisfies the pending read immediately
      assign rbusy_c[k] = !rst && (a_c != '0) && busy_q[a_c] && !(hit1_c || hit0_c);
   end

   assign bus.rD    = rd_c;
   assign bus.rbusy = rbusy_c;
endmodule

// File: tb/tb_rf_mp_sb.sv
// Directed bench for rf_mp_sb: a 3-read-port 32x32 instance and a 64-bit 8-entry instance.
module tb_rf_mp_sb;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   rf_mp_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3)) ifa ();
   rf_mp_sb_if #(.DATA_W(64), .ADDR_W(3), .NUM_RD(2)) ifb ();

   rf_mp_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   rf_mp_sb #(.DATA_W(64), .ADDR_W(3), .NUM_RD(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [63:0] mdl [8];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ifa.we0 = 1'b0; ifa.we1 = 1'b0; ifa.iss_v = 1'b0; ifa.flush = 1'b0;
      ifb.we0 = 1'b0; ifb.we1 = 1'b0; ifb.iss_v = 1'b0; ifb.flush = 1'b0;
   endtask

   task automatic rda(input logic [4:0] a);
      ifa.rR = {a, a, a};
      #1;
   endtask

   function automatic logic [31:0] da(input int k);
      return ifa.rD[k*32 +: 32];
   endfunction

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      ifa.rR = '0; ifa.wR0 = '0; ifa.wD0 = '0; ifa.wR1 = '0; ifa.wD1 = '0; ifa.iss_rd = '0;
      ifb.rR = '0; ifb.wR0 = '0; ifb.wD0 = '0; ifb.wR1 = '0; ifb.wD1 = '0; ifb.iss_rd = '0;
      idle();
      rda(5'd5);
      chk("reset_rd", 64'(da(0)), 64'h0);
      chk("reset_busy", 64'(ifa.rbusy), 64'h0);
      tick();
      rst = 1'b0;

      // Write x5, issue x5, then asynchronous reset between edges
      ifa.we0 = 1'b1; ifa.wR0 = 5'd5; ifa.wD0 = 32'hDEADBEEF;
      rda(5'd5);
      chk("x5_bypass", 64'(da(0)), 64'hDEADBEEF);
      tick();
      idle();
      ifa.iss_v = 1'b1; ifa.iss_rd = 5'd5;
      rda(5'd5);
      chk("x5_stored", 64'(da(1)), 64'hDEADBEEF);
      tick();
      idle();
      rda(5'd5);
      chk("x5_busy", 64'(ifa.rbusy), 64'h7);
      rst = 1'b1;
      ifa.we1 = 1'b1; ifa.wR1 = 5'd5; ifa.wD1 = 32'h5555;
      #1;
      chk("rst_rd_gated", 64'(da(2)), 64'h0);
      chk("rst_busy_gated", 64'(ifa.rbusy), 64'h0);
      ifa.we1 = 1'b0;
      #1;
      rst = 1'b0;
      tick();
      rda(5'd5);
      chk("post_rst_rd", 64'(da(0)), 64'h0);
      chk("post_rst_busy", 64'(ifa.rbusy), 64'h0);

      // x0 protection
      ifa.we0 = 1'b1; ifa.wR0 = 5'd0; ifa.wD0 = 32'h1234;
      rda(5'd0);
      chk("x0_same_cycle", 64'(da(0)), 64'h0);
      tick();
      idle();
      chk("x0_after_edge", 64'(da(1)), 64'h0);
      ifa.iss_v = 1'b1; ifa.iss_rd = 5'd0;
      tick();
      idle();
      rda(5'd0);
      chk("x0_never_busy", 64'(ifa.rbusy), 64'h0);

      // Dual write to x7: port 1 wins in bypass and storage, on all three read ports
      ifa.we0 = 1'b1; ifa.wR0 = 5'd7; ifa.wD0 = 32'h11;
      ifa.we1 = 1'b1; ifa.wR1 = 5'd7; ifa.wD1 = 32'h22;
      rda(5'd7);
      chk("x7_byp_p0", 64'(da(0)), 64'h22);
      chk("x7_byp_p1", 64'(da(1)), 64'h22);
      chk("x7_byp_p2", 64'(da(2)), 64'h22);
      tick();
      idle();
      rda(5'd7);
      chk("x7_st_p0", 64'(da(0)), 64'h22);
      chk("x7_st_p2", 64'(da(2)), 64'h22);

      // Distinct addresses on both write ports
      ifa.we0 = 1'b1; ifa.wR0 = 5'd8; ifa.wD0 = 32'hAA;
      ifa.we1 = 1'b1; ifa.wR1 = 5'd9; ifa.wD1 = 32'hBB;
      ifa.rR = {5'd7, 5'd9, 5'd8};
      #1;
      chk("split_p0_x8", 64'(da(0)), 64'hAA);
      chk("split_p1_x9", 64'(da(1)), 64'hBB);
      chk("split_p2_x7", 64'(da(2)), 64'h22);
      tick();
      idle();
      chk("split_st_x8", 64'(da(0)), 64'hAA);

      // Scoreboard: issue x3, busy for three cycles, cleared by same-cycle write-back
      ifa.iss_v = 1'b1; ifa.iss_rd = 5'd3;
      rda(5'd3);
      tick();
      idle();
      chk("x3_busy_c2", 64'(ifa.rbusy), 64'h7);
      tick();
      chk("x3_busy_c3", 64'(ifa.rbusy), 64'h7);
      tick();
      chk("x3_busy_c4", 64'(ifa.rbusy), 64'h7);
      tick();
      ifa.we0 = 1'b1; ifa.wR0 = 5'd3; ifa.wD0 = 32'h3333;
      #1;
      chk("x3_wb_busy", 64'(ifa.rbusy), 64'h0);
      chk("x3_wb_rd", 64'(da(1)), 64'h3333);
      tick();
      idle();
      #1;
      chk("x3_after_busy", 64'(ifa.rbusy), 64'h0);
      chk("x3_after_rd", 64'(da(2)), 64'h3333);

      // Set/clear collision on x9
      ifa.iss_v = 1'b1; ifa.iss_rd = 5'd9;
      rda(5'd9);
      tick();
      idle();
      chk("x9_busy", 64'(ifa.rbusy), 64'h7);
      ifa.iss_v = 1'b1; ifa.iss_rd = 5'd9;
      ifa.we1 = 1'b1; ifa.wR1 = 5'd9; ifa.wD1 = 32'h99;
      #1;
      chk("x9_coll_busy", 64'(ifa.rbusy), 64'h0);
      chk("x9_coll_rd", 64'(da(0)), 64'h99);
      tick();
      idle();
      #1;
      chk("x9_still_busy", 64'(ifa.rbusy), 64'h7);
      chk("x9_updated", 64'(da(1)), 64'h99);
      ifa.flush = 1'b1; ifa.iss_v = 1'b1; ifa.iss_rd = 5'd9;
      tick();
      idle();
      #1;
      chk("x9_flush_busy", 64'(ifa.rbusy), 64'h0);
      chk("x9_flush_keeps", 64'(da(2)), 64'h99);

      // Double issue is not counted: one write-back clears
      ifa.iss_v = 1'b1; ifa.iss_rd = 5'd4;
      rda(5'd4);
      tick();
      tick();
      idle();
      chk("x4_busy", 64'(ifa.rbusy), 64'h7);
      ifa.we0 = 1'b1; ifa.wR0 = 5'd4; ifa.wD0 = 32'h44;
      tick();
      idle();
      #1;
      chk("x4_cleared", 64'(ifa.rbusy), 64'h0);

      // 64-bit, 8-entry instance
      ifb.we0 = 1'b1; ifb.wR0 = 3'd7; ifb.wD0 = 64'hFFFF_FFFF_0000_0001;
      tick();
      idle();
      ifb.rR = {3'd0, 3'd7};
      #1;
      chk("b_x7_wide", ifb.rD[63:0], 64'hFFFF_FFFF_0000_0001);
      chk("b_x0_zero", ifb.rD[127:64], 64'h0);

      for (int i = 0; i < 8; i++) mdl[i] = 64'h0;
      mdl[7] = 64'hFFFF_FFFF_0000_0001;
      for (int i = 0; i < 8; i++) begin
         logic [63:0] d;
         d = {$urandom, $urandom};
         if (i % 2 == 0) begin
            ifb.we0 = 1'b1; ifb.wR0 = 3'(i); ifb.wD0 = d;
         end else begin
            ifb.we1 = 1'b1; ifb.wR1 = 3'(i); ifb.wD1 = d;
         end
         if (i != 0) mdl[i] = d;
         tick();
         idle();
      end
      for (int i = 0; i < 8; i++) begin
         ifb.rR = {3'(7 - i), 3'(i)};
         #1;
         chk($sformatf("b_rand_p0_x%0d", i), ifb.rD[63:0], mdl[i]);
         chk($sformatf("b_rand_p1_x%0d", 7 - i), ifb.rD[127:64], mdl[7-i]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
